// File: rtl/jk_excite_seq.sv
// jk_excite_seq: steps a negedge JK flip-flop bank through a programmed state table and verifies each arrival
module jk_excite_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    len,
  input  logic             loop,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    step_idx
);
  typedef enum logic [2:0] {IDLE, DRIVE, CHECK, FIN, FAIL} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [WIDTH-1:0] target, j_n, k_n;
  logic [AW-1:0] len_q, len_n, step_n;
  logic loop_q, loop_n, busy_n, done_n, err_n;
  assign target = tbl[step_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) tbl <= '{default: '0};
    else if (wr_en && !busy) tbl[wr_addr] <= wr_data;
  always_comb begin
    state_n = state;
    j_n = '0;
    k_n = '0;
    busy_n = busy;
    done_n = done;
    err_n = err;
    step_n = step_idx;
    len_n = len_q;
    loop_n = loop_q;
    if (abort) begin
      state_n = IDLE;
      busy_n = 1'b0;
      step_n = '0;
    end else begin
      case (state)
        IDLE, FIN, FAIL:
          if (start) begin
            state_n = DRIVE;
            len_n = len;
            loop_n = loop;
            step_n = '0;
            done_n = 1'b0;
            err_n = 1'b0;
            busy_n = 1'b1;
          end
        DRIVE: begin
          // set only the bits that must change; toggle is never issued
          j_n = ~q_fb & target;
          k_n = q_fb & ~target;
          state_n = CHECK;
        end
        CHECK:
          if (q_fb != target) begin
            err_n = 1'b1;
            busy_n = 1'b0;
            state_n = FAIL;
          end else if (step_idx != len_q) begin
            step_n = step_idx + 1'b1;
            state_n = DRIVE;
          end else if (loop_q) begin
            step_n = '0;
            state_n = DRIVE;
          end else begin
            done_n = 1'b1;
            busy_n = 1'b0;
            state_n = FIN;
          end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      j <= '0;
      k <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      step_idx <= '0;
      len_q <= '0;
      loop_q <= 1'b0;
    end else begin
      state <= state_n;
      j <= j_n;
      k <= k_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
      step_idx <= step_n;
      len_q <= len_n;
      loop_q <= loop_n;
    end
endmodule

// File: tb/tb_jk_excite_seq.sv
// tb_jk_excite_seq: directed scenarios against a behavioural negedge JK bank with stuck-at-0 injection
module tb_jk_excite_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0, start = 1'b0, abort = 1'b0, loop = 1'b0;
  logic [2:0] wr_addr = '0, len = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] q_fb, j, k;
  logic busy, done, err;
  logic [2:0] step_idx;
  logic [3:0] bank = '0, stuck0 = '0, pre_val = '0;
  logic pre_en = 1'b0;
  int total = 0, bad = 0;

  jk_excite_seq dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .loop(loop), .start(start), .abort(abort), .q_fb(q_fb),
    .j(j), .k(k), .busy(busy), .done(done), .err(err), .step_idx(step_idx)
  );

  always #5 clk = ~clk;
  always @(negedge clk) bank <= pre_en ? pre_val : ((j & ~bank) | (~k & bank));
  assign q_fb = bank & ~stuck0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] v);
    pre_val = v;
    pre_en = 1'b1;
    @(negedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic write_tbl(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [2:0] l, input logic lp);
    start = 1'b1;
    len = l;
    loop = lp;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    total++;
    if ({j, k, busy, done, err, step_idx} !== 14'd0) begin
      bad++;
      $display("FAIL reset_state: got j=%b k=%b busy=%b done=%b err=%b step=%0d, want all 0", j, k, busy, done, err, step_idx);
    end
  endtask

  task automatic test_sequence;
    logic [7:0] ejk [4];
    ejk = '{8'b0000_1110, 8'b0010_0000, 8'b0000_0001, 8'b0000_0010};
    write_tbl(0, 4'd1); write_tbl(1, 4'd3); write_tbl(2, 4'd2); write_tbl(3, 4'd0);
    preload(4'hf);
    go(3, 1'b0);
    total++;
    if ({busy, step_idx, j, k} !== {1'b1, 3'd0, 8'd0}) begin
      bad++;
      $display("FAIL seq_start: got busy=%b step=%0d jk=%b, want busy=1 step=0 jk=0", busy, step_idx, {j, k});
    end
    for (int s = 0; s < 4; s++) begin
      tick;
      total++;
      if ({j, k} !== ejk[s]) begin
        bad++;
        $display("FAIL seq_drive%0d: got j=%b k=%b, want j=%b k=%b", s, j, k, ejk[s][7:4], ejk[s][3:0]);
      end
      tick;
      total++;
      if ({step_idx, j, k} !== {(s == 3) ? 3'd3 : 3'(s + 1), 8'd0}) begin
        bad++;
        $display("FAIL seq_check%0d: got step=%0d jk=%b, want step=%0d jk=0", s, step_idx, {j, k}, (s == 3) ? 3 : s + 1);
      end
    end
    total++;
    if ({busy, done, err, q_fb} !== {3'b010, 4'd0}) begin
      bad++;
      $display("FAIL seq_done: got busy=%b done=%b err=%b bank=%b, want 0 1 0 0000", busy, done, err, q_fb);
    end
    tick;
    tick;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL seq_done_held: got done=%b, want 1", done);
    end
  endtask

  task automatic test_loop_abort;
    preload(4'h0);
    go(3, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick;
      tick;
      total++;
      if ({step_idx, done, busy} !== {3'(i % 4), 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL loop_step%0d: got step=%0d done=%b busy=%b, want step=%0d done=0 busy=1", i, step_idx, done, busy, i % 4);
      end
    end
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if ({j, k, busy, done, err, step_idx} !== 14'd0) begin
      bad++;
      $display("FAIL loop_abort: got j=%b k=%b busy=%b done=%b err=%b step=%0d, want all 0", j, k, busy, done, err, step_idx);
    end
    tick;
    total++;
    if ({busy, j, k} !== 9'd0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%b jk=%b, want 0 0", busy, {j, k});
    end
  endtask

  task automatic test_fault;
    preload(4'h0);
    write_tbl(0, 4'b0100);
    stuck0 = 4'b0100;
    go(0, 1'b0);
    tick;
    total++;
    if ({j, k} !== 8'b0100_0000) begin
      bad++;
      $display("FAIL fault_drive: got j=%b k=%b, want j=0100 k=0000", j, k);
    end
    tick;
    total++;
    if ({busy, done, err, j, k} !== {3'b001, 8'd0}) begin
      bad++;
      $display("FAIL fault_err: got busy=%b done=%b err=%b jk=%b, want 0 0 1 0", busy, done, err, {j, k});
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if ({j, k, err} !== 9'b1) begin
        bad++;
        $display("FAIL fault_hold%0d: got jk=%b err=%b, want jk=0 err=1", i, {j, k}, err);
      end
    end
    stuck0 = 4'b0000;
  endtask

  task automatic test_reset_mid_run;
    preload(4'h0);
    go(0, 1'b0);
    tick;
    total++;
    if (j !== 4'b0100) begin
      bad++;
      $display("FAIL rst_pre_drive: got j=%b, want 0100", j);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({j, k, busy, done, err, step_idx} !== 14'd0) begin
      bad++;
      $display("FAIL rst_async: got j=%b k=%b busy=%b done=%b err=%b step=%0d, want all 0", j, k, busy, done, err, step_idx);
    end
    rst = 1'b0;
    tick;
    go(3, 1'b0);
    for (int s = 0; s < 4; s++) begin
      tick;
      total++;
      if ({j, k} !== 8'd0) begin
        bad++;
        $display("FAIL rst_tbl_zero%0d: got j=%b k=%b, want 0 0", s, j, k);
      end
      tick;
    end
    total++;
    if ({done, err, busy, q_fb} !== {3'b100, 4'd0}) begin
      bad++;
      $display("FAIL rst_rerun: got done=%b err=%b busy=%b bank=%b, want 1 0 0 0000", done, err, busy, q_fb);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ejk [4];
    ejk = '{8'b0000_1110, 8'b0010_0000, 8'b0000_0001, 8'b0000_0010};
    write_tbl(0, 4'd1); write_tbl(1, 4'd3); write_tbl(2, 4'd2); write_tbl(3, 4'd0);
    preload(4'hf);
    go(3, 1'b0);
    tick;
    total++;
    if ({j, k} !== ejk[0]) begin
      bad++;
      $display("FAIL b2b_drive0: got j=%b k=%b, want j=0000 k=1110", j, k);
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'b1010;
    start = 1'b1; len = 3'd0;
    tick;
    wr_en = 1'b0; start = 1'b0;
    total++;
    if ({step_idx, busy} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL b2b_ignore_start: got step=%0d busy=%b, want step=1 busy=1", step_idx, busy);
    end
    for (int s = 1; s < 4; s++) begin
      tick;
      total++;
      if ({j, k} !== ejk[s]) begin
        bad++;
        $display("FAIL b2b_drive%0d: got j=%b k=%b, want j=%b k=%b", s, j, k, ejk[s][7:4], ejk[s][3:0]);
      end
      tick;
    end
    total++;
    if ({done, err, step_idx, q_fb} !== {2'b10, 3'd3, 4'd0}) begin
      bad++;
      $display("FAIL b2b_done: got done=%b err=%b step=%0d bank=%b, want 1 0 3 0000", done, err, step_idx, q_fb);
    end
    go(0, 1'b0);
    tick;
    total++;
    if ({j, k} !== 8'b0001_0000) begin
      bad++;
      $display("FAIL b2b_tbl_kept: got j=%b k=%b, want j=0001 k=0000", j, k);
    end
    tick;
  endtask

  task automatic test_hold;
    write_tbl(2, 4'd3);
    go(2, 1'b0);
    tick;
    total++;
    if ({j, k} !== 8'd0) begin
      bad++;
      $display("FAIL hold_drive0: got j=%b k=%b, want 0 0", j, k);
    end
    tick;
    total++;
    if ({step_idx, err} !== {3'd1, 1'b0}) begin
      bad++;
      $display("FAIL hold_check0: got step=%0d err=%b, want 1 0", step_idx, err);
    end
    tick;
    total++;
    if ({j, k} !== 8'b0010_0000) begin
      bad++;
      $display("FAIL hold_drive1: got j=%b k=%b, want j=0010 k=0000", j, k);
    end
    tick;
    tick;
    total++;
    if ({j, k} !== 8'd0) begin
      bad++;
      $display("FAIL hold_drive2: got j=%b k=%b, want 0 0", j, k);
    end
    tick;
    total++;
    if ({done, err, busy, q_fb} !== {3'b100, 4'b0011}) begin
      bad++;
      $display("FAIL hold_done: got done=%b err=%b busy=%b bank=%b, want 1 0 0 0011", done, err, busy, q_fb);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_sequence;
    test_loop_abort;
    test_fault;
    test_reset_mid_run;
    test_back_to_back;
    test_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
